// File: rtl/rs_pkg.sv
// rs_pkg: shared types and constants for the Reed-Solomon decoder datapath
// block-memory scheduling (bank states, bank count, block lengths).
package rs_pkg;

    localparam int unsigned NBANK         = 3;
    localparam int unsigned BANK_IDX_W    = 2;
    localparam int unsigned BLK_CODED_LEN = 204;
    localparam int unsigned BLK_DATA_LEN  = 188;

    typedef enum logic [2:0] {
        BANK_FREE  = 3'd0,
        BANK_FILL  = 3'd1,
        BANK_CORR  = 3'd2,
        BANK_READY = 3'd3,
        BANK_DRAIN = 3'd4
    } bank_state_t;

    typedef logic [BANK_IDX_W-1:0] bank_idx_t;

endpackage

// File: rtl/rs_bank_ptr.sv
// rs_bank_ptr: 2-bit round-robin bank pointer, wraps from NBANK-1 back to 0
// on each advance.
module rs_bank_ptr #(
    parameter int unsigned NBANK = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_adv,
    output logic [1:0] o_ptr
);
    import rs_pkg::*;

    bank_idx_t r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (r_ptr == bank_idx_t'(NBANK - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rs_bank_scheduler.sv
// rs_bank_scheduler: moves the three shared RS block memories through
// FILL -> CORR -> READY -> DRAIN. Optional counters: RS_SCHED_STATS_EN.
module rs_bank_scheduler #(
    parameter int unsigned NBANK = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_start,
    input  logic       wr_done,
    output logic       wr_grant,
    output logic [1:0] wr_bank,
    output logic       cor_start,
    output logic [1:0] cor_bank,
    input  logic       cor_done,
    output logic       rd_start,
    output logic [1:0] rd_bank,
    input  logic       out_done,
    output logic       overflow,
    output logic       busy
`ifdef RS_SCHED_STATS_EN
   ,output logic [15:0] blk_cnt,
    output logic [7:0]  drop_cnt
`endif
);
    import rs_pkg::*;

    bank_state_t r_bank     [NBANK];
    bank_state_t w_bank_nxt [NBANK];

    bank_idx_t w_wr_ptr, w_cor_ptr, w_rd_ptr;
    bank_idx_t r_wr_bank, r_cor_bank, r_rd_bank;

    logic r_wr_busy, r_cor_busy, r_rd_busy;
    logic r_out_done_q, r_out_rise;
    logic r_wr_grant, r_overflow, r_cor_start, r_rd_start, r_busy;

    logic w_wr_grant, w_wr_ovf, w_wr_fin;
    logic w_cor_issue, w_cor_fin;
    logic w_rd_issue, w_rd_fin;
    logic w_busy_nxt;

    // Every decision reads registered bank state only, so a bank released
    // on this edge is first seen by the allocators on the following edge.
    always_comb begin
        w_wr_grant  = wr_start && !r_wr_busy && (r_bank[w_wr_ptr] == BANK_FREE);
        w_wr_ovf    = wr_start && !r_wr_busy && (r_bank[w_wr_ptr] != BANK_FREE);
        w_wr_fin    = wr_done && r_wr_busy;
        w_cor_issue = !r_cor_busy && (r_bank[w_cor_ptr] == BANK_CORR);
        w_cor_fin   = cor_done && r_cor_busy;
        w_rd_issue  = !r_rd_busy && (r_bank[w_rd_ptr] == BANK_READY);
        w_rd_fin    = r_out_rise && r_rd_busy;
        w_busy_nxt  = 1'b0;
        for (int unsigned i = 0; i < NBANK; i++) begin
            w_bank_nxt[i] = r_bank[i];
            if (w_wr_grant && (w_wr_ptr == bank_idx_t'(i)))   w_bank_nxt[i] = BANK_FILL;
            if (w_wr_fin   && (r_wr_bank == bank_idx_t'(i)))  w_bank_nxt[i] = BANK_CORR;
            if (w_cor_fin  && (r_cor_bank == bank_idx_t'(i))) w_bank_nxt[i] = BANK_READY;
            if (w_rd_issue && (w_rd_ptr == bank_idx_t'(i)))   w_bank_nxt[i] = BANK_DRAIN;
            if (w_rd_fin   && (r_rd_bank == bank_idx_t'(i)))  w_bank_nxt[i] = BANK_FREE;
            if (w_bank_nxt[i] != BANK_FREE) w_busy_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NBANK; i++) r_bank[i] <= BANK_FREE;
            r_wr_busy    <= 1'b0;
            r_cor_busy   <= 1'b0;
            r_rd_busy    <= 1'b0;
            r_wr_bank    <= '0;
            r_cor_bank   <= '0;
            r_rd_bank    <= '0;
            r_out_done_q <= 1'b0;
            r_out_rise   <= 1'b0;
            r_wr_grant   <= 1'b0;
            r_overflow   <= 1'b0;
            r_cor_start  <= 1'b0;
            r_rd_start   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NBANK; i++) r_bank[i] <= w_bank_nxt[i];
            r_out_done_q <= out_done;
            r_out_rise   <= out_done && !r_out_done_q;
            r_wr_grant   <= w_wr_grant;
            r_overflow   <= w_wr_ovf;
            r_cor_start  <= w_cor_issue;
            r_rd_start   <= w_rd_issue;
            r_busy       <= w_busy_nxt;

            if (w_wr_grant) begin
                r_wr_busy <= 1'b1;
                r_wr_bank <= w_wr_ptr;
            end else if (w_wr_fin) begin
                r_wr_busy <= 1'b0;
            end

            if (w_cor_issue) begin
                r_cor_busy <= 1'b1;
                r_cor_bank <= w_cor_ptr;
            end else if (w_cor_fin) begin
                r_cor_busy <= 1'b0;
            end

            if (w_rd_issue) begin
                r_rd_busy <= 1'b1;
                r_rd_bank <= w_rd_ptr;
            end else if (w_rd_fin) begin
                r_rd_busy <= 1'b0;
            end
        end
    end

    rs_bank_ptr #(.NBANK(NBANK)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_wr_grant),
        .o_ptr (w_wr_ptr)
    );

    rs_bank_ptr #(.NBANK(NBANK)) u_cor_ptr (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_cor_fin),
        .o_ptr (w_cor_ptr)
    );

    rs_bank_ptr #(.NBANK(NBANK)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_adv (w_rd_fin),
        .o_ptr (w_rd_ptr)
    );

    assign wr_grant  = r_wr_grant;
    assign wr_bank   = r_wr_bank;
    assign cor_start = r_cor_start;
    assign cor_bank  = r_cor_bank;
    assign rd_start  = r_rd_start;
    assign rd_bank   = r_rd_bank;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

`ifdef RS_SCHED_STATS_EN
    logic [15:0] r_blk_cnt;
    logic [7:0]  r_drop_cnt;

    // blk_cnt wraps; drop_cnt saturates so a long outage stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blk_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_rd_fin) r_blk_cnt <= r_blk_cnt + 1'b1;
            if (w_wr_ovf && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign blk_cnt  = r_blk_cnt;
    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_rs_bank_scheduler.sv
// tb_rs_bank_scheduler: scoreboard bench for rs_bank_scheduler; stats
// scenario is compiled in when RS_SCHED_STATS_EN is defined.
module tb_rs_bank_scheduler;

    localparam logic [1:0] K_GRANT = 2'd0;
    localparam logic [1:0] K_OVF   = 2'd1;
    localparam logic [1:0] K_COR   = 2'd2;
    localparam logic [1:0] K_RD    = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  bank;
        logic [31:0] cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_start = 1'b0, wr_done = 1'b0, cor_done = 1'b0, out_done = 1'b0;
    logic wr_grant, cor_start, rd_start, overflow, busy;
    logic [1:0] wr_bank, cor_bank, rd_bank;
`ifdef RS_SCHED_STATS_EN
    logic [15:0] blk_cnt;
    logic [7:0]  drop_cnt;
`endif

    ev_t exp_q[$];
    ev_t obs_q[$];
    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] cyc = 32'd0;

    rs_bank_scheduler #(.NBANK(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_start  (wr_start),
        .wr_done   (wr_done),
        .wr_grant  (wr_grant),
        .wr_bank   (wr_bank),
        .cor_start (cor_start),
        .cor_bank  (cor_bank),
        .cor_done  (cor_done),
        .rd_start  (rd_start),
        .rd_bank   (rd_bank),
        .out_done  (out_done),
        .overflow  (overflow),
        .busy      (busy)
`ifdef RS_SCHED_STATS_EN
       ,.blk_cnt   (blk_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Output pulses are recorded with the index of the edge that launched them.
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_grant)  obs_q.push_back(ev_t'{K_GRANT, wr_bank, cyc});
            if (overflow)  obs_q.push_back(ev_t'{K_OVF, wr_bank, cyc});
            if (cor_start) obs_q.push_back(ev_t'{K_COR, cor_bank, cyc});
            if (rd_start)  obs_q.push_back(ev_t'{K_RD, rd_bank, cyc});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1);
    end

    task automatic expect_ev(input logic [1:0] k, input logic [1:0] b, input logic [31:0] cy);
        exp_q.push_back(ev_t'{k, b, cy});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_start = 1'b0; wr_done = 1'b0; cor_done = 1'b0; out_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic pulse_wr_start(output logic [31:0] c);
        @(negedge clk); wr_start = 1'b1; c = cyc;
        @(negedge clk); wr_start = 1'b0;
    endtask

    task automatic pulse_wr_done(output logic [31:0] c);
        @(negedge clk); wr_done = 1'b1; c = cyc;
        @(negedge clk); wr_done = 1'b0;
    endtask

    task automatic pulse_cor_done(output logic [31:0] c);
        @(negedge clk); cor_done = 1'b1; c = cyc;
        @(negedge clk); cor_done = 1'b0;
    endtask

    task automatic run_block(input logic [1:0] b);
        logic [31:0] c;
        pulse_wr_start(c); expect_ev(K_GRANT, b, c + 32'd1);
        pulse_wr_done(c);  expect_ev(K_COR, b, c + 32'd2);
        repeat (2) @(negedge clk);
        pulse_cor_done(c); expect_ev(K_RD, b, c + 32'd2);
        repeat (2) @(negedge clk);
        @(negedge clk); out_done = 1'b1;
        repeat (3) @(negedge clk); out_done = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({wr_bank, cor_bank, rd_bank} !== {b, b, b}) begin
            n_bad++;
            $display("FAIL block_banks: wr/cor/rd bank %0d/%0d/%0d, required %0d/%0d/%0d",
                     wr_bank, cor_bank, rd_bank, b, b, b);
        end
    endtask

    task automatic test_reset();
        logic [31:0] c;
        ev_t e, o;
        apply_reset();
        n_vec++;
        if ({wr_grant, wr_bank, cor_start, cor_bank, rd_start, rd_bank, overflow, busy} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {wr_grant, wr_bank, cor_start, cor_bank, rd_start, rd_bank, overflow, busy});
        end
        // Completions to idle stages must be ignored.
        pulse_cor_done(c);
        pulse_wr_done(c);
        @(negedge clk); out_done = 1'b1;
        repeat (3) @(negedge clk); out_done = 1'b0;
        repeat (4) @(negedge clk); #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy: busy %b, required 0", busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL reset_ev: missing kind %0d bank %0d cyc %0d", e.kind, e.bank, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL reset_ev: got kind %0d bank %0d cyc %0d, required kind %0d bank %0d cyc %0d",
                             o.kind, o.bank, o.cyc, e.kind, e.bank, e.cyc);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL reset_extra: %0d unexpected pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_single_block();
        logic [31:0] c;
        ev_t e, o;
        apply_reset();
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd0, c + 32'd1);
        repeat (207) @(negedge clk);
        pulse_wr_done(c);  expect_ev(K_COR, 2'd0, c + 32'd2);
        repeat (48) @(negedge clk);
        pulse_cor_done(c); expect_ev(K_RD, 2'd0, c + 32'd2);
        repeat (1536) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL single_busy_drain: busy %b, required 1", busy);
        end
        @(negedge clk); out_done = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL single_busy_edge: busy %b, required 1", busy);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_free: busy %b, required 0", busy);
        end
        out_done = 1'b0;
        repeat (4) @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL single_ev: missing kind %0d bank %0d cyc %0d", e.kind, e.bank, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL single_ev: got kind %0d bank %0d cyc %0d, required kind %0d bank %0d cyc %0d",
                             o.kind, o.bank, o.cyc, e.kind, e.bank, e.cyc);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL single_extra: %0d unexpected pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c;
        ev_t e, o;
        apply_reset();
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd0, c + 32'd1);
        pulse_wr_start(c);                     // writer still holds bank 0: ignored
        pulse_wr_done(c);  expect_ev(K_COR, 2'd0, c + 32'd2);
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd1, c + 32'd1);
        pulse_wr_done(c);
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd2, c + 32'd1);
        pulse_wr_done(c);
        pulse_wr_start(c); expect_ev(K_OVF, 2'd2, c + 32'd1);
        pulse_wr_done(c);                      // writer idle: ignored
        repeat (4) @(negedge clk); #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL b2b_busy: busy %b, required 1", busy);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL b2b_ev: missing kind %0d bank %0d cyc %0d", e.kind, e.bank, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL b2b_ev: got kind %0d bank %0d cyc %0d, required kind %0d bank %0d cyc %0d",
                             o.kind, o.bank, o.cyc, e.kind, e.bank, e.cyc);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_extra: %0d unexpected pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_pointer_wrap();
        ev_t e, o;
        apply_reset();
        run_block(2'd0);
        run_block(2'd1);
        run_block(2'd2);
        run_block(2'd0);
        repeat (2) @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL wrap_ev: missing kind %0d bank %0d cyc %0d", e.kind, e.bank, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL wrap_ev: got kind %0d bank %0d cyc %0d, required kind %0d bank %0d cyc %0d",
                             o.kind, o.bank, o.cyc, e.kind, e.bank, e.cyc);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL wrap_extra: %0d unexpected pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] c;
        ev_t e, o;
        apply_reset();
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd0, c + 32'd1);
        pulse_wr_done(c);  expect_ev(K_COR, 2'd0, c + 32'd2);
        repeat (2) @(negedge clk);
        pulse_cor_done(c); expect_ev(K_RD, 2'd0, c + 32'd2);
        repeat (2) @(negedge clk);
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd1, c + 32'd1);
        pulse_wr_done(c);  expect_ev(K_COR, 2'd1, c + 32'd2);
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd2, c + 32'd1);
        pulse_wr_done(c);
        // Bank 0 is freed on the same edge that samples this wr_start.
        @(negedge clk); out_done = 1'b1; c = cyc;
        @(negedge clk); wr_start = 1'b1;
        @(negedge clk); wr_start = 1'b0;
        @(negedge clk); wr_start = 1'b1;
        @(negedge clk); wr_start = 1'b0; out_done = 1'b0;
        expect_ev(K_OVF, 2'd2, c + 32'd2);
        expect_ev(K_GRANT, 2'd0, c + 32'd4);
        repeat (4) @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL same_ev: missing kind %0d bank %0d cyc %0d", e.kind, e.bank, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL same_ev: got kind %0d bank %0d cyc %0d, required kind %0d bank %0d cyc %0d",
                             o.kind, o.bank, o.cyc, e.kind, e.bank, e.cyc);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL same_extra: %0d unexpected pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] c;
        ev_t e, o;
        apply_reset();
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd0, c + 32'd1);
        pulse_wr_done(c);  expect_ev(K_COR, 2'd0, c + 32'd2);
        repeat (2) @(negedge clk);
        pulse_cor_done(c); expect_ev(K_RD, 2'd0, c + 32'd2);
        repeat (2) @(negedge clk);
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd1, c + 32'd1);
        pulse_wr_done(c);  expect_ev(K_COR, 2'd1, c + 32'd2);
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd2, c + 32'd1);
        repeat (3) @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL mid_ev: missing kind %0d bank %0d cyc %0d", e.kind, e.bank, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL mid_ev: got kind %0d bank %0d cyc %0d, required kind %0d bank %0d cyc %0d",
                             o.kind, o.bank, o.cyc, e.kind, e.bank, e.cyc);
                end
            end
        end
        // Banks now FILL(2) / CORR(1) / DRAIN(0); reset lands between edges.
        @(negedge clk); #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({wr_grant, wr_bank, cor_start, cor_bank, rd_start, rd_bank, overflow, busy} !== 11'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %b, required all zero",
                     {wr_grant, wr_bank, cor_start, cor_bank, rd_start, rd_bank, overflow, busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        pulse_wr_start(c); expect_ev(K_GRANT, 2'd0, c + 32'd1);
        repeat (3) @(negedge clk); #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL post_reset_ev: missing kind %0d bank %0d cyc %0d", e.kind, e.bank, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL post_reset_ev: got kind %0d bank %0d cyc %0d, required kind %0d bank %0d cyc %0d",
                             o.kind, o.bank, o.cyc, e.kind, e.bank, e.cyc);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_bad++; $display("FAIL post_reset_extra: %0d unexpected pulses, required 0", obs_q.size());
            obs_q.delete();
        end
    endtask

`ifdef RS_SCHED_STATS_EN
    task automatic test_stats();
        logic [31:0] c;
        apply_reset();
        for (int b = 0; b < 3; b++) begin
            pulse_wr_start(c);
            pulse_wr_done(c);
        end
        @(negedge clk); wr_start = 1'b1;
        repeat (254) @(negedge clk);
        n_vec++;
        if (drop_cnt !== 8'd254) begin
            n_bad++; $display("FAIL drop_254: drop_cnt %0d, required 254", drop_cnt);
        end
        @(negedge clk);
        n_vec++;
        if (drop_cnt !== 8'd255) begin
            n_bad++; $display("FAIL drop_255: drop_cnt %0d, required 255", drop_cnt);
        end
        repeat (45) @(negedge clk);
        wr_start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (drop_cnt !== 8'd255) begin
            n_bad++; $display("FAIL drop_sat: drop_cnt %0d, required 255", drop_cnt);
        end
        apply_reset();
        run_block(2'd0);
        run_block(2'd1);
        run_block(2'd2);
        run_block(2'd0);
        run_block(2'd1);
        n_vec++;
        if (blk_cnt !== 16'd5) begin
            n_bad++; $display("FAIL blk_cnt: blk_cnt %0d, required 5", blk_cnt);
        end
        exp_q.delete();
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_pointer_wrap();
        test_same_cycle();
        test_reset_mid_drain();
`ifdef RS_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
